// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Brief    : Shared types and default widths for the systolic feed blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  localparam int DEF_DATA_W    = 64;
  localparam int DEF_IN_ADDR_W = 12;
  localparam int DEF_WT_ADDR_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO, power-of-two depth, with count/full/empty.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign empty = (r_count == CW'(0));
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;

  // Simultaneous read+write is legal when full or empty; the empty case falls through.
  assign w_wr_ok = wr_en && (!full || rd_en);
  assign w_rd_ok = rd_en && (!empty || wr_en);
  assign rd_data = empty ? wr_data : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + CW'(1);
      end else if (!w_wr_ok && w_rd_ok) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : bram_stream_reader
//  Brief    : Lockstep input/weight BRAM read sequencer with credit-based
//             latency absorption and a valid/ready paired-word output stream.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_stream_reader
  import systolic_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int IN_ADDR_W  = DEF_IN_ADDR_W,
  parameter int WT_ADDR_W  = DEF_WT_ADDR_W,
  parameter int LEN_W      = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IN_ADDR_W-1:0] in_base,
  input  logic [WT_ADDR_W-1:0] wt_base,
  input  logic [LEN_W-1:0]     len,
  input  logic [LEN_W-1:0]     wt_len,
  output logic                 busy,
  output logic                 done,
  output logic                 in_en,
  output logic [IN_ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0]    in_dout,
  output logic                 wt_en,
  output logic [WT_ADDR_W-1:0] wt_addr,
  input  logic [DATA_W-1:0]    wt_dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_in_data,
  output logic [DATA_W-1:0]    out_wt_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_t            r_state;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_wt_len;
  logic [LEN_W-1:0]     r_issue_cnt;
  logic [LEN_W-1:0]     r_wt_cnt;
  logic [IN_ADDR_W-1:0] r_in_addr;
  logic [WT_ADDR_W-1:0] r_wt_base;
  logic [WT_ADDR_W-1:0] r_wt_addr;
  logic                 r_busy;
  logic                 r_done;
  logic [RD_LAT-1:0]    r_vpipe;

  logic [CW-1:0]         w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [2*DATA_W-1:0]   w_fifo_rdata;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_can_issue;
  logic                  w_drained;
  logic [7:0]            w_vsum;
  logic [7:0]            w_pending;

  assign w_pop = !w_fifo_empty && out_ready;

  always_comb begin
    w_vsum = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_vsum = w_vsum + 8'(r_vpipe[i]);
    end
  end

  // Entries that will still need FIFO room once this cycle's pop retires.
  assign w_pending   = 8'(w_fifo_count) + w_vsum - 8'(w_pop);
  assign w_can_issue = (w_pending < 8'(FIFO_DEPTH)) && !(w_fifo_full && !w_pop);
  assign w_issue     = (r_state == ST_ISSUE) && w_can_issue;

  assign w_drained = (r_vpipe == '0) &&
                     ((w_fifo_count == CW'(0)) || ((w_fifo_count == CW'(1)) && w_pop));

  generate
    if (RD_LAT == 1) begin : g_pipe_single
      always_ff @(posedge clk) begin
        if (rst) r_vpipe <= '0;
        else     r_vpipe <= w_issue;
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk) begin
        if (rst) r_vpipe <= '0;
        else     r_vpipe <= {r_vpipe[RD_LAT-2:0], w_issue};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_wt_len    <= '0;
      r_issue_cnt <= '0;
      r_wt_cnt    <= '0;
      r_in_addr   <= '0;
      r_wt_base   <= '0;
      r_wt_addr   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_len       <= len;
            r_wt_len    <= wt_len;
            r_issue_cnt <= '0;
            r_wt_cnt    <= '0;
            r_in_addr   <= in_base;
            r_wt_base   <= wt_base;
            r_wt_addr   <= wt_base;
            r_busy      <= 1'b1;
            if (len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + LEN_W'(1);
            r_in_addr   <= r_in_addr + IN_ADDR_W'(1);
            if ((r_wt_len != '0) && (r_wt_cnt == r_wt_len - LEN_W'(1))) begin
              r_wt_addr <= r_wt_base;
              r_wt_cnt  <= '0;
            end else begin
              r_wt_addr <= r_wt_addr + WT_ADDR_W'(1);
              r_wt_cnt  <= r_wt_cnt + LEN_W'(1);
            end
            if (r_issue_cnt == r_len - LEN_W'(1)) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (r_vpipe[RD_LAT-1]),
    .wr_data ({in_dout, wt_dout}),
    .rd_en   (w_pop),
    .rd_data (w_fifo_rdata),
    .count   (w_fifo_count),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign in_en       = w_issue;
  assign wt_en       = w_issue;
  assign in_addr     = r_in_addr;
  assign wt_addr     = r_wt_addr;
  assign out_valid   = !w_fifo_empty;
  assign out_in_data = w_fifo_empty ? '0 : w_fifo_rdata[2*DATA_W-1:DATA_W];
  assign out_wt_data = w_fifo_empty ? '0 : w_fifo_rdata[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_stream_reader
//  Brief    : Self-checking bench driving RD_LAT=1 and RD_LAT=3 instances.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

  localparam int DW  = 64;
  localparam int IAW = 12;
  localparam int WAW = 11;
  localparam int LW  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           out_ready = 1'b0;
  logic [IAW-1:0] in_base = '0;
  logic [WAW-1:0] wt_base = '0;
  logic [LW-1:0]  len = '0;
  logic [LW-1:0]  wt_len = '0;

  logic           busy_s[2], done_s[2], in_en_s[2], wt_en_s[2], out_valid_s[2];
  logic [IAW-1:0] in_addr_s[2];
  logic [WAW-1:0] wt_addr_s[2];
  logic [DW-1:0]  in_dout_s[2], wt_dout_s[2], oin_s[2], owt_s[2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cmd_cyc = 0;
  bit active = 1'b0;
  int cur_len = 0;
  int mode = 0;

  int issue_idx[2], beat_idx[2], first_en[2], first_val[2], done_rel[2];
  bit prev_stall[2];
  logic [DW-1:0] prev_in[2], prev_wt[2];

  logic [IAW-1:0] exp_ia[$];
  logic [WAW-1:0] exp_wa[$];
  logic [DW-1:0]  exp_in[$];
  logic [DW-1:0]  exp_wt[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] hin(input logic [11:0] a);
    return {a, 20'h3C5A1, a, 8'h5E, a};
  endfunction

  function automatic logic [63:0] hwt(input logic [10:0] a);
    return {a, 21'h1B2F7, a, 10'h2A5, a};
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // BRAM models: address captured on enable, data appears RD_LAT cycles later
  logic [IAW-1:0] ia_p[2][3];
  logic [WAW-1:0] wa_p[2][3];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (in_en_s[d]) ia_p[d][0] <= in_addr_s[d];
      if (wt_en_s[d]) wa_p[d][0] <= wt_addr_s[d];
      ia_p[d][1] <= ia_p[d][0];
      ia_p[d][2] <= ia_p[d][1];
      wa_p[d][1] <= wa_p[d][0];
      wa_p[d][2] <= wa_p[d][1];
    end
  end
  assign in_dout_s[0] = hin(ia_p[0][0]);
  assign wt_dout_s[0] = hwt(wa_p[0][0]);
  assign in_dout_s[1] = hin(ia_p[1][2]);
  assign wt_dout_s[1] = hwt(wa_p[1][2]);

  bram_stream_reader #(.DATA_W(DW), .IN_ADDR_W(IAW), .WT_ADDR_W(WAW), .LEN_W(LW),
                       .RD_LAT(1), .FIFO_DEPTH(4)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start), .in_base(in_base), .wt_base(wt_base),
    .len(len), .wt_len(wt_len), .busy(busy_s[0]), .done(done_s[0]),
    .in_en(in_en_s[0]), .in_addr(in_addr_s[0]), .in_dout(in_dout_s[0]),
    .wt_en(wt_en_s[0]), .wt_addr(wt_addr_s[0]), .wt_dout(wt_dout_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready),
    .out_in_data(oin_s[0]), .out_wt_data(owt_s[0]));

  bram_stream_reader #(.DATA_W(DW), .IN_ADDR_W(IAW), .WT_ADDR_W(WAW), .LEN_W(LW),
                       .RD_LAT(3), .FIFO_DEPTH(4)) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start), .in_base(in_base), .wt_base(wt_base),
    .len(len), .wt_len(wt_len), .busy(busy_s[1]), .done(done_s[1]),
    .in_en(in_en_s[1]), .in_addr(in_addr_s[1]), .in_dout(in_dout_s[1]),
    .wt_en(wt_en_s[1]), .wt_addr(wt_addr_s[1]), .wt_dout(wt_dout_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready),
    .out_in_data(oin_s[1]), .out_wt_data(owt_s[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_busy"},  64'(busy_s[d]), 64'd0);
      chk({tag, "_done"},  64'(done_s[d]), 64'd0);
      chk({tag, "_in_en"}, 64'(in_en_s[d]), 64'd0);
      chk({tag, "_wt_en"}, 64'(wt_en_s[d]), 64'd0);
      chk({tag, "_valid"}, 64'(out_valid_s[d]), 64'd0);
      chk({tag, "_iaddr"}, 64'(in_addr_s[d]), 64'd0);
      chk({tag, "_waddr"}, 64'(wt_addr_s[d]), 64'd0);
      chk({tag, "_oin"},   oin_s[d], 64'd0);
      chk({tag, "_owt"},   owt_s[d], 64'd0);
    end
  endtask

  // Per-cycle monitor, sampled on the falling edge
  always @(negedge clk) begin
    int  rel;
    bit  pop;
    if (active) begin
      rel = cyc - cmd_cyc;
      for (int d = 0; d < 2; d++) begin
        if (rel == 1) chk("busy_rise", 64'(busy_s[d]), 64'd1);
        chk("wt_en_lockstep", 64'(wt_en_s[d]), 64'(in_en_s[d]));
        if (in_en_s[d]) begin
          if (first_en[d] < 0) first_en[d] = rel;
          if (issue_idx[d] < cur_len) begin
            chk("in_addr", 64'(in_addr_s[d]), 64'(exp_ia[issue_idx[d]]));
            chk("wt_addr", 64'(wt_addr_s[d]), 64'(exp_wa[issue_idx[d]]));
            if (mode == 0) chk("issue_cycle", 64'(rel), 64'(issue_idx[d] + 1));
          end else begin
            chk("extra_issue", 64'(issue_idx[d] + 1), 64'(cur_len));
          end
          issue_idx[d]++;
        end
        if (prev_stall[d]) begin
          chk("stall_valid", 64'(out_valid_s[d]), 64'd1);
          chk("stall_in",    oin_s[d], prev_in[d]);
          chk("stall_wt",    owt_s[d], prev_wt[d]);
        end
        if (out_valid_s[d] && first_val[d] < 0) first_val[d] = rel;
        pop = out_valid_s[d] && out_ready;
        if (pop) begin
          if (beat_idx[d] < cur_len) begin
            chk("beat_in", oin_s[d], exp_in[beat_idx[d]]);
            chk("beat_wt", owt_s[d], exp_wt[beat_idx[d]]);
            if (mode == 0) chk("beat_cycle", 64'(rel), 64'(2 + lat(d) + beat_idx[d]));
          end else begin
            chk("extra_beat", 64'(beat_idx[d] + 1), 64'(cur_len));
          end
          beat_idx[d]++;
        end
        chk("outstanding_le_4", 64'((issue_idx[d] - beat_idx[d]) <= 4), 64'd1);
        prev_stall[d] = out_valid_s[d] && !out_ready;
        prev_in[d] = oin_s[d];
        prev_wt[d] = owt_s[d];
        if (done_s[d]) begin
          if (done_rel[d] >= 0) chk("done_twice", 64'(rel), 64'(done_rel[d]));
          done_rel[d] = rel;
          chk("done_all_beats", 64'(beat_idx[d]), 64'(cur_len));
        end
        if (done_rel[d] >= 0 && rel == done_rel[d] + 1) chk("busy_fall", 64'(busy_s[d]), 64'd0);
      end
    end
  end

  // rmode: 0 = ready always high, 1 = ready 1,0,0,1 repeating, 2 = random ready
  task automatic run_cmd(input logic [IAW-1:0] ib, input logic [WAW-1:0] wb,
                         input logic [LW-1:0] ln, input logic [LW-1:0] wl, input int rmode);
    exp_ia.delete(); exp_wa.delete(); exp_in.delete(); exp_wt.delete();
    for (int k = 0; k < int'(ln); k++) begin
      logic [IAW-1:0] ia;
      logic [WAW-1:0] wa;
      ia = ib + IAW'(k);
      wa = wb + WAW'((wl == 0) ? k : (k % int'(wl)));
      exp_ia.push_back(ia);
      exp_wa.push_back(wa);
      exp_in.push_back(hin(ia));
      exp_wt.push_back(hwt(wa));
    end
    for (int d = 0; d < 2; d++) begin
      issue_idx[d] = 0; beat_idx[d] = 0; first_en[d] = -1;
      first_val[d] = -1; done_rel[d] = -1; prev_stall[d] = 1'b0;
    end
    cur_len = int'(ln);
    mode    = rmode;
    in_base = ib; wt_base = wb; len = ln; wt_len = wl;
    start = 1'b1; out_ready = 1'b1;
    cmd_cyc = cyc;
    active  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 3000; k++) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (((k - 1) % 4) == 0) || (((k - 1) % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (done_rel[0] >= 0 && done_rel[1] >= 0 && k > done_rel[0] + 2 && k > done_rel[1] + 2) break;
      @(posedge clk); #1;
    end
    active = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("done_seen", 64'(done_rel[d] >= 0), 64'd1);
      chk("issue_total", 64'(issue_idx[d]), 64'(ln));
      chk("beat_total", 64'(beat_idx[d]), 64'(ln));
      if (ln != 0) chk("first_en_cycle", 64'(first_en[d]), 64'd1);
      if (rmode == 0) begin
        chk("done_cycle", 64'(done_rel[d]), (ln == 0) ? 64'd1 : 64'(int'(ln) + lat(d) + 2));
        if (ln != 0) chk("first_valid_cycle", 64'(first_val[d]), 64'(2 + lat(d)));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmd(12'd0, 11'd0, 16'd8, 16'd0, 0);
    run_cmd(12'd0, 11'd0, 16'd16, 16'd0, 1);
    run_cmd(12'd37, 11'd100, 16'd7, 16'd3, 0);
    run_cmd(12'd5, 11'd5, 16'd0, 16'd0, 0);
    run_cmd(12'd4094, 11'd2046, 16'd4, 16'd0, 0);

    // Abort mid-run while the RD_LAT=1 instance holds two stalled beats
    in_base = 12'd200; wt_base = 11'd300; len = 16'd16; wt_len = 16'd0;
    out_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_prefill_valid", 64'(out_valid_s[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_quiet("abort");
    repeat (5) begin
      @(posedge clk); #1;
      chk("abort_no_done_l1", 64'(done_s[0]), 64'd0);
      chk("abort_no_done_l3", 64'(done_s[1]), 64'd0);
    end
    run_cmd(12'd10, 11'd20, 16'd2, 16'd0, 0);

    repeat (6) begin
      run_cmd(IAW'($urandom), WAW'($urandom), LW'($urandom_range(1, 24)),
              LW'($urandom_range(0, 5)), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_stream_reader.md
# bram_stream_reader

Parametrised dual-BRAM read sequencer feeding the systolic array. A single start command makes it generate lockstep addresses for the im2col input BRAM and the convolution weight BRAM. It absorbs the BRAM read latency and delivers paired input/weight words on a valid/ready stream with full backpressure. Weight addresses can optionally rewind, so one weight tile is reused across a longer input run.

## Interface
Parameters:
- DATA_W, 64, width of each BRAM data word
- IN_ADDR_W, 12, input BRAM address width
- WT_ADDR_W, 11, weight BRAM address width
- LEN_W, 16, width of beat-count fields
- RD_LAT, 1, BRAM read latency in cycles (1..3)
- FIFO_DEPTH, 4, output buffer entries (power of 2, ≥ RD_LAT+1)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  command pulse; sampled only in IDLE
- in_base  in  IN_ADDR_W  first input address
- wt_base  in  WT_ADDR_W  first weight address
- len  in  LEN_W  total beats to deliver
- wt_len  in  LEN_W  weight rewind period; 0 disables rewind
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the last beat is transferred
- in_en  out  1  input BRAM enable
- in_addr  out  IN_ADDR_W  input BRAM address
- in_dout  in  DATA_W  input BRAM read data
- wt_en  out  1  weight BRAM enable (always equal to in_en)
- wt_addr  out  WT_ADDR_W  weight BRAM address
- wt_dout  in  DATA_W  weight BRAM read data
- out_valid  out  1  paired beat available
- out_ready  in  1  consumer accepts the beat
- out_in_data  out  DATA_W  input word of the beat
- out_wt_data  out  DATA_W  weight word of the beat

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start` latches all command fields. If `len`=0, go to DONE; otherwise go to ISSUE.
- ISSUE: a read is issued (`in_en`=`wt_en`=1) in any cycle where inflight + fifo_count < FIFO_DEPTH.
  - Each issue advances `in_addr` by 1, modulo 2^IN_ADDR_W.
  - `wt_addr` also advances by 1. When rewind is enabled and `wt_len` issues have occurred since the last rewind, `wt_addr` returns to `wt_base` instead.
  - After `len` issues, go to DRAIN.
- DRAIN: wait until inflight = 0 and the FIFO is empty, including the final handshake, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- A valid-tracking shift register of RD_LAT stages follows each issue. Its output writes {`in_dout`, `wt_dout`} into the FIFO. The credit rule guarantees the FIFO never overflows, so returning data is never dropped.
- Outputs: `out_valid` = FIFO non-empty. A beat transfers when `out_valid` && `out_ready`. Data holds stable while valid and not ready.
- `start` is ignored while `busy`.
- Reset mid-operation returns the block to IDLE and flushes the FIFO and the latency pipe. No `done` is produced, and the aborted command is lost.
- Reset values: `busy`, `done`, `in_en`, `wt_en`, `out_valid` = 0; `in_addr`, `wt_addr`, `out_in_data`, `out_wt_data` = 0.

## Timing
- Start sampled at edge 0. First issue (`in_en`=1, `in_addr`=`in_base`) occurs in cycle 1.
- Data from an issue in cycle t is valid on `*_dout` in cycle t+RD_LAT and is written to the FIFO at the end of that cycle.
- First `out_valid` is in cycle 2+RD_LAT.
- With `out_ready` held high, one beat per cycle is sustained.
- The last beat at cycle T gives `done` in cycle T+1 and `busy` low in cycle T+2.
- With `len`=0, `done` occurs in cycle 1 and no BRAM enables are issued.
- `busy` rises in cycle 1.
- A FIFO read and write in the same cycle are allowed with the FIFO full or empty; the count is unchanged.

## Structure
- Shared package (`systolic_pkg`): state enum; default widths DATA_W, IN_ADDR_W, WT_ADDR_W.
- Sub-module `sync_fifo`: parametrised DEPTH and WIDTH, synchronous `rst`, exposing count, full and empty.
- Address/credit sequencer and latency pipe live in this module.

## Test plan
- Basic stream: RD_LAT=1, `in_base`=0, `wt_base`=0, `len`=8, `out_ready`=1.
  - `in_addr` 0..7 in cycles 1..8.
  - Beats equal to BRAM contents at 0..7 in cycles 3..10.
  - `done` in cycle 11.
- Backpressure: `len`=16 with `out_ready` toggling 1,0,0,1 repeating.
  - No lost or duplicated beats; order is preserved.
  - Outstanding reads (inflight + fifo_count) never exceed 4 (FIFO_DEPTH).
  - Data stays stable while stalled.
- Weight rewind: `wt_base`=100, `wt_len`=3, `len`=7.
  - `wt_addr` sequence 100,101,102,100,101,102,100.
  - `in_addr` is linear.
- Zero length: `len`=0 gives `done` in cycle 1, with `in_en` never asserted.
- Address wrap: `in_base`=4094, `len`=4 gives `in_addr` 4094, 4095, 0, 1.
- Reset abort: `rst` asserted mid-run with 2 beats in the FIFO.
  - Next cycle: all outputs 0, state IDLE, no `done`.
  - A following start with `len`=2 completes normally.
- Repeat the basic stream with RD_LAT=3 and FIFO_DEPTH=4: first `out_valid` in cycle 5, then full throughput.
